// File: rtl/muxn_seq_pkg.sv
// muxn_seq_pkg: mode encodings and select-width helper shared by the muxn_seq block
package muxn_seq_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int selw_f(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/muxn_seq_ctr.sv
// muxn_seq_ctr: wrapping 0..NCH-1 scan counter with synchronous clear
module muxn_seq_ctr
    import muxn_seq_pkg::*;
#(
    parameter int NCH = 3,
    localparam int CW = selw_f(NCH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = int'(cnt) == NCH - 1;

    // clear wins over advance; advance wraps after the last channel
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= last ? '0 : cnt + 1'b1;

endmodule

// File: rtl/muxn_seq.sv
// muxn_seq: registered N-channel mux, direct or auto-scan select; sel_err check under MUXN_SEQ_SELERR_EN
module muxn_seq
    import muxn_seq_pkg::*;
#(
    parameter int W = 9,
    parameter int NCH = 3,
    localparam int SELW = selw_f(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH*W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [SELW-1:0]  sel,
    output logic [W-1:0]     out_data,
    output logic [SELW-1:0]  out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             scan_last,
    output logic             sel_err
);

    logic [W-1:0]    chans [NCH];
    logic [SELW-1:0] ch;
    logic [SELW-1:0] cnt;
    logic            cnt_last;
    logic            acc;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign chans[k] = in_data[k*W +: W];
    end

    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;
    assign ch       = (mode == MODE_SCAN) ? cnt : sel;

    muxn_seq_ctr #(.NCH(NCH)) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (acc && mode == MODE_SCAN),
        .clr   (mode == MODE_DIRECT),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // output stage: load on accept, drop valid once consumed, hold under backpressure
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            scan_last <= 1'b0;
        end else if (acc) begin
            out_data  <= (int'(ch) < NCH) ? chans[ch] : '0;
            out_ch    <= ch;
            out_valid <= 1'b1;
            scan_last <= (mode == MODE_SCAN) && cnt_last;
        end else if (out_ready)
            out_valid <= 1'b0;

`ifdef MUXN_SEQ_SELERR_EN
    // sticky flag for a direct-mode beat addressing a channel that does not exist
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            sel_err <= 1'b0;
        else if (acc && mode == MODE_DIRECT && int'(sel) >= NCH)
            sel_err <= 1'b1;
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_muxn_seq.sv
// tb_muxn_seq: scoreboard bench for muxn_seq (W=9, NCH=3)
module tb_muxn_seq;

    typedef struct {
        logic [8:0] d;
        logic [1:0] c;
        logic       l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [26:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [8:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        scan_last;
    logic        sel_err;

    beat_t q[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic  exp_err;

    muxn_seq #(.W(9), .NCH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .scan_last (scan_last),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic m, input logic [1:0] s, input logic v);
        @(posedge clk);
        #1;
        mode = m;
        sel = s;
        in_valid = v;
    endtask

    task automatic expect_beat(input logic [8:0] d, input logic [1:0] c, input logic l);
        beat_t b;
        b.d = d;
        b.c = c;
        b.l = l;
        q.push_back(b);
    endtask

    always @(negedge clk)
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 32'(out_ch), 32'hFFFF);
            end else begin
                beat_t b;
                b = q.pop_front();
                chk("out_data", 32'(out_data), 32'(b.d));
                chk("out_ch", 32'(out_ch), 32'(b.c));
                chk("scan_last", 32'(scan_last), 32'(b.l));
            end
        end

    initial begin
`ifdef MUXN_SEQ_SELERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n = 1'b0;
        in_data = {9'd4, 9'd2, 9'd1};
        in_valid = 1'b0;
        out_ready = 1'b1;
        mode = 1'b0;
        sel = 2'd0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_scan_last", 32'(scan_last), 0);
        chk("rst_sel_err", 32'(sel_err), 0);
        #14 rst_n = 1'b1;

        // direct mode, in-range then out-of-range select
        drive(0, 0, 1); expect_beat(9'd1, 2'd0, 0);
        drive(0, 1, 1); expect_beat(9'd2, 2'd1, 0);
        drive(0, 2, 1); expect_beat(9'd4, 2'd2, 0);
        drive(0, 3, 1); expect_beat(9'd0, 2'd3, 0);
        drive(0, 0, 0);
        chk("sel_err_set", 32'(sel_err), 32'(exp_err));
        drive(0, 0, 0);
        chk("idle_out_valid", 32'(out_valid), 0);
        drive(0, 0, 1); expect_beat(9'd1, 2'd0, 0);
        drive(0, 0, 0);
        chk("sel_err_sticky", 32'(sel_err), 32'(exp_err));

        // scan: seven beats wrap 0,1,2,0,1,2,0
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 1);
            expect_beat((i % 3 == 0) ? 9'd1 : (i % 3 == 1) ? 9'd2 : 9'd4, 2'(i % 3), i % 3 == 2);
        end
        drive(1, 0, 0);
        drive(1, 0, 0);

        // backpressure: hold channel-1 beat for 4 cycles, then continue at channel 2
        drive(1, 0, 1);
        out_ready = 1'b0;
        expect_beat(9'd2, 2'd1, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_data", 32'(out_data), 2);
            chk("bp_out_ch", 32'(out_ch), 1);
        end
        out_ready = 1'b1;
        expect_beat(9'd4, 2'd2, 1);
        drive(1, 0, 1); expect_beat(9'd1, 2'd0, 0);

        // one direct cycle while cnt=1 restarts the scan at channel 0
        drive(0, 0, 0);
        drive(1, 0, 1); expect_beat(9'd1, 2'd0, 0);
        drive(1, 0, 0);

        // reset pulse drops a held beat
        drive(1, 0, 1);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_out_ch", 32'(out_ch), 0);
        chk("mid_rst_sel_err", 32'(sel_err), 0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1, 0, 1); expect_beat(9'd1, 2'd0, 0);
        drive(1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muxn_seq.md
MUXN_SEQ -- requirements
Module: muxn_seq

Interface
REQ-001 Parameter W, default 9: data width per channel, in bits (W >= 1).
REQ-002 Parameter NCH, default 3: number of input channels (NCH >= 2).
REQ-003 Local parameter SELW = max(1, clog2(NCH)): width of the select and channel-index fields.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port in_data, input, NCH*W bits: channel k occupies bits [k*W +: W].
REQ-007 Port in_valid, input, 1 bit: the in_data/sel beat is valid.
REQ-008 Port in_ready, output, 1 bit: the block can accept a beat.
REQ-009 Port mode, input, 1 bit: 0 = direct select, 1 = auto-scan.
REQ-010 Port sel, input, SELW bits: channel index used in direct mode.
REQ-011 Port out_data, output, W bits: the registered selected channel.
REQ-012 Port out_ch, output, SELW bits: the channel index that produced out_data.
REQ-013 Port out_valid, output, 1 bit: out_data, out_ch and scan_last are valid.
REQ-014 Port out_ready, input, 1 bit: the downstream consumer accepts the output.
REQ-015 Port scan_last, output, 1 bit: the output beat came from channel NCH-1 in scan mode.
REQ-016 Port sel_err, output, 1 bit: sticky out-of-range select flag (see Configuration).

Function
REQ-017 A beat shall be accepted when in_valid && in_ready; in_ready = !out_valid || out_ready (one-stage registered pipe with no bubble).
REQ-018 The channel index ch shall be sel when mode=0 and the scan counter cnt when mode=1, evaluated in the accepting cycle.
REQ-019 On accept, out_data shall load in_data slice ch, or all-zero when ch >= NCH.
- On the same edge out_ch shall load ch and out_valid shall go to 1.
- Latency from accept to out_valid is 1 cycle.
REQ-020 When out_valid=1 and out_ready=1 with no new accept, out_valid shall go to 0 on the next edge.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_ch, out_valid and scan_last shall hold stable.
REQ-022 Scan counter cnt, 0..NCH-1:
- increments on each accept with mode=1;
- wraps from NCH-1 to 0;
- is forced to 0 on any cycle with mode=0.
REQ-023 scan_last shall be registered with the beat; it is 1 only when mode=1 and ch=NCH-1.
REQ-024 A mode change takes effect at the next accept; a 0->1 transition always starts the scan at channel 0.
REQ-025 A non-accepted cycle (in_valid=0 or in_ready=0) shall not change cnt.

Reset
REQ-026 While rst_n=0, asynchronously: out_data=0, out_ch=0, out_valid=0, scan_last=0, sel_err=0, cnt=0.
- in_ready reads 1 during reset.
REQ-027 Reset asserted mid-transfer shall drop the pending output beat with no partial state retained; the first accept after release uses channel 0 in scan mode.

Configuration
REQ-028 Macro MUXN_SEQ_SELERR_EN defined: sel_err shall set on any accept with mode=0 and sel >= NCH, and clear only on reset.
REQ-029 Macro MUXN_SEQ_SELERR_EN undefined: sel_err shall be tied to 0 and the check logic shall not be present; the data path (zero output) is unchanged.

Structure
REQ-030 Package muxn_seq_pkg shall hold MODE_DIRECT=1'b0, MODE_SCAN=1'b1 and the SELW computation function.
REQ-031 The scan counter shall be the sub-module muxn_seq_ctr (ports: clk, rst_n, en, clr, cnt, last), parametrised by NCH.

Verification
REQ-032 Direct mode, W=9, NCH=3, in_data={9'd4,9'd2,9'd1}, out_ready=1, sel=0,1,2 on consecutive cycles -> out_data 1,2,4 one cycle after each accept; out_ch 0,1,2.
REQ-033 Direct mode, sel=3 (NCH=3) -> out_data=0, out_ch=3.
- With MUXN_SEQ_SELERR_EN: sel_err=1 and stays 1 until reset.
- Without it: sel_err=0.
REQ-034 Scan mode, in_valid=1 for 7 cycles, out_ready=1 -> out_ch 0,1,2,0,1,2,0 with scan_last=1 on the beats with out_ch=2 only.
REQ-035 Backpressure: out_ready=0 for 4 cycles with one beat held -> in_ready=0 and outputs stable; after out_ready=1, the next scan beat continues at the following channel with none skipped.
REQ-036 Scan at cnt=1, then mode=0 for one cycle, then mode=1 -> the next scan beat has out_ch=0.
REQ-037 rst_n pulsed low between clock edges while out_valid=1 -> out_valid=0 immediately; after release the first scan beat has out_ch=0.
